// File: rtl/proc_ctrl_pkg.sv
// Shared types and default widths for the processor run controller.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP
  } state_e;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RID_W_DEF  = 4;
  localparam int unsigned NREGS_DEF  = 16;
  localparam int unsigned CYC_W_DEF  = 16;

endpackage

// File: rtl/proc_run_timer.sv
// Loadable saturating down-counter; expired_o is high once the count reaches zero.
module proc_run_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/proc_run_ctrl.sv
// Load / run / register-dump sequencer for the single-cycle processor core.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RID_W  = RID_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned CYC_W  = CYC_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              src_req,
  output logic [ADDR_W-1:0] src_addr,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [DATA_W-1:0] wDat,
  output logic              working,
  output logic [RID_W-1:0]  rID,
  input  logic [DATA_W-1:0] rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [RID_W-1:0]  dump_id,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  localparam logic [RID_W-1:0] LAST_ID = RID_W'(NREGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, src_addr_q, buf_idx_q, addr_q;
  logic [DATA_W-1:0] buf_dat_q, wdat_q, dump_data_q;
  logic [RID_W-1:0]  rid_q, dump_id_q;
  logic              run_zero_q, acc_done_q, buf_vld_q, wen_q;
  logic              dump_valid_q, done_q;
  logic              start_acc, accept, last_write, dump_hs, timer_expired;
  logic [CYC_W-1:0]  timer_val;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign accept     = src_req && src_valid;
  assign last_write = wen_q && (addr_q == len_q - ADDR_W'(1));
  assign dump_hs    = dump_valid_q && dump_ready;
  // Timer is loaded at start with R-1 so it expires on the last working cycle.
  assign timer_val  = (run_cycles == '0) ? '0 : run_cycles - CYC_W'(1);

  proc_run_timer #(.W(CYC_W)) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (start_acc),
    .load_val_i (timer_val),
    .en_i       (state_q == ST_RUN),
    .expired_o  (timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        if (prog_len != '0)        state_d = ST_LOAD;
        else if (run_cycles != '0) state_d = ST_RUN;
        else                       state_d = ST_DUMP;
      end
      ST_LOAD: if (last_write)    state_d = run_zero_q ? ST_DUMP : ST_RUN;
      ST_RUN:  if (timer_expired) state_d = ST_DUMP;
      ST_DUMP: if (done_q)        state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_req = (state_q == ST_LOAD) && !acc_done_q;
    working = (state_q == ST_RUN);
    busy    = (state_q != ST_IDLE);
  end

  // Accepted words pass through a one-entry buffer before the imem write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      run_zero_q <= 1'b0;
      src_addr_q <= '0;
      acc_done_q <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_dat_q  <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
    end else begin
      if (start_acc) begin
        len_q      <= prog_len;
        run_zero_q <= (run_cycles == '0);
        src_addr_q <= '0;
        acc_done_q <= 1'b0;
      end else if (accept) begin
        if (src_addr_q == len_q - ADDR_W'(1)) acc_done_q <= 1'b1;
        else                                  src_addr_q <= src_addr_q + ADDR_W'(1);
      end
      buf_vld_q <= accept;
      if (accept) begin
        buf_idx_q <= src_addr_q;
        buf_dat_q <= src_data;
      end
      wen_q <= buf_vld_q;
      if (buf_vld_q) begin
        addr_q <= buf_idx_q;
        wdat_q <= buf_dat_q;
      end
    end
  end

  // Each register: one settle cycle after rID changes, then capture and hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rid_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_id_q    <= '0;
      dump_data_q  <= '0;
      done_q       <= 1'b0;
    end else if (state_q != ST_DUMP) begin
      rid_q        <= '0;
      dump_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (done_q) begin
      done_q <= 1'b0;
    end else if (dump_hs) begin
      dump_valid_q <= 1'b0;
      if (rid_q == LAST_ID) done_q <= 1'b1;
      else                  rid_q  <= rid_q + RID_W'(1);
    end else if (!dump_valid_q) begin
      dump_valid_q <= 1'b1;
      dump_id_q    <= rid_q;
      dump_data_q  <= rdata;
    end
  end

  assign src_addr   = src_addr_q;
  assign addr       = addr_q;
  assign wEn        = wen_q;
  assign wDat       = wdat_q;
  assign rID        = rid_q;
  assign dump_valid = dump_valid_q;
  assign dump_id    = dump_id_q;
  assign dump_data  = dump_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized bench for proc_run_ctrl against a sequence-level reference model.
module tb_proc_run_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RID_W  = 4;
  localparam int NREGS  = 16;
  localparam int CYC_W  = 16;
  localparam int BUDGET = 4000;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] prog_len = '0;
  logic [CYC_W-1:0]  run_cycles = '0;
  logic              src_req;
  logic [ADDR_W-1:0] src_addr;
  logic              src_valid = 1'b0;
  logic [DATA_W-1:0] src_data;
  logic [ADDR_W-1:0] addr;
  logic              wEn;
  logic [DATA_W-1:0] wDat;
  logic              working;
  logic [RID_W-1:0]  rID;
  logic [DATA_W-1:0] rdata;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [RID_W-1:0]  dump_id;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] rom [512];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  assign src_data = src_valid ? rom[src_addr] : 32'hDEAD_BEEF;
  assign rdata    = 32'hA000_0000 | 32'(rID);

  proc_run_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RID_W  (RID_W),
    .NREGS  (NREGS),
    .CYC_W  (CYC_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .src_req    (src_req),
    .src_addr   (src_addr),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .addr       (addr),
    .wEn        (wEn),
    .wDat       (wDat),
    .working    (working),
    .rID        (rID),
    .rdata      (rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_id    (dump_id),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observed events of the current sequence.
  int          wr_addr_q[$];
  logic [31:0] wr_dat_q[$];
  int          wr_cyc_q[$];
  int          dmp_id_q[$];
  logic [31:0] dmp_dat_q[$];
  int work_cnt, work_first, work_last, dump_first, last_hs, done_cnt, done_cyc;
  bit dump_seen;

  logic              prev_dv, prev_rdy, prev_req, prev_sv;
  logic [RID_W-1:0]  prev_id;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_dv  = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (wEn) begin
        wr_addr_q.push_back(int'(addr));
        wr_dat_q.push_back(wDat);
        wr_cyc_q.push_back(cyc);
        check_eq("wen_vs_working", 128'(working), 128'(0));
      end
      if (working) begin
        if (work_cnt == 0) work_first = cyc;
        work_last = cyc;
        work_cnt++;
      end
      if (dump_valid && !dump_seen) begin
        dump_seen  = 1'b1;
        dump_first = cyc;
      end
      if (dump_valid && dump_ready) begin
        dmp_id_q.push_back(int'(dump_id));
        dmp_dat_q.push_back(dump_data);
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_dv && !prev_rdy)
        check_eq("dump_hold", 128'({dump_valid, dump_id, dump_data}), 128'({1'b1, prev_id, prev_data}));
      if (prev_req && !prev_sv)
        check_eq("src_hold", 128'({src_req, src_addr}), 128'({1'b1, prev_addr}));
      prev_dv   = dump_valid;
      prev_rdy  = dump_ready;
      prev_id   = dump_id;
      prev_data = dump_data;
      prev_req  = src_req;
      prev_sv   = src_valid;
      prev_addr = src_addr;
    end
  end

  task automatic clear_obs();
    wr_addr_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
    dmp_id_q.delete();  dmp_dat_q.delete();
    work_cnt = 0; work_first = -1; work_last = -1;
    dump_first = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
    dump_seen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"},
             128'({src_req, src_addr, addr, wEn, working, rID, dump_valid, dump_id, busy, done}), 128'(0));
    check_eq({tag, "_data"}, 128'({wDat, dump_data}), 128'(0));
  endtask

  // vmode: 0 src_valid tied high, 1 every 3rd cycle, 2 random. rmode: 0 ready tied, 1 random.
  task automatic run_seq(input int len, input int r, input int vmode, input int rmode, input bit poke);
    int c0, n, d;
    bit poked_load, poked_dump;
    clear_obs();
    @(posedge clock); #1;
    prog_len   = ADDR_W'(len);
    run_cycles = CYC_W'(r);
    start      = 1'b1;
    c0         = cyc + 1;
    @(posedge clock); #1;
    start      = 1'b0;
    prog_len   = ADDR_W'($urandom);
    run_cycles = CYC_W'($urandom);
    n = 0; poked_load = 1'b0; poked_dump = 1'b0;
    while (done_cnt == 0 && n < BUDGET) begin
      src_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      dump_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = 1'b0;
      if (poke && !poked_load && src_req)    begin start = 1'b1; poked_load = 1'b1; end
      if (poke && !poked_dump && dump_valid) begin start = 1'b1; poked_dump = 1'b1; end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    @(posedge clock); #1;
    check_eq("idle_after_done", 128'({busy, done}), 128'(0));
    check_eq("done_count", 128'(done_cnt), 128'(1));
    check_eq("done_after_hs", 128'(done_cyc), 128'(last_hs + 1));

    check_eq("n_writes", 128'(wr_addr_q.size()), 128'(len));
    for (int k = 0; k < len && k < wr_addr_q.size(); k++) begin
      check_eq("wr_addr", 128'(wr_addr_q[k]), 128'(k));
      check_eq("wr_data", 128'(wr_dat_q[k]), 128'(rom[k]));
      if (vmode == 0) check_eq("wr_cycle", 128'(wr_cyc_q[k]), 128'(c0 + 2 + k));
    end

    check_eq("work_cycles", 128'(work_cnt), 128'(r));
    if (r > 0) begin
      check_eq("work_contig", 128'(work_last - work_first + 1), 128'(r));
      if (len > 0) check_eq("work_after_load", 128'(work_first), 128'(wr_cyc_q[$] + 1));
      check_eq("dump_after_work", 128'(dump_first), 128'(work_last + 2));
    end

    check_eq("n_dumps", 128'(dmp_id_q.size()), 128'(NREGS));
    for (int i = 0; i < NREGS && i < dmp_id_q.size(); i++) begin
      check_eq("dump_id", 128'(dmp_id_q[i]), 128'(i));
      check_eq("dump_data", 128'(dmp_dat_q[i]), 128'(32'hA000_0000 + i));
    end

    // Edge on which DUMP is entered, derived from the load/run timing rules.
    if (vmode == 0) begin
      d = ((len == 0) ? c0 : c0 + 2 + len) + r;
      check_eq("dump_first", 128'(dump_first), 128'(d + 1));
      if (rmode == 0) check_eq("done_cycle", 128'(done_cyc), 128'(d + 2 * NREGS));
    end
  endtask

  initial begin
    automatic logic [31:0] prog[12] = '{32'h10f00001, 32'h10f1000a, 32'h10f20014, 32'h10f3001e,
                                        32'h10f40028, 32'h10f50032, 32'h41000065, 32'h41100066,
                                        32'h41200067, 32'h40300065, 32'h40400066, 32'h40500067};
    int n;
    for (int i = 0; i < 512; i++) rom[i] = (i < 12) ? prog[i] : $urandom;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    run_seq(12, 25, 0, 0, 1'b0);
    run_seq(12, 25, 1, 0, 1'b0);
    run_seq(12, 8, 0, 1, 1'b0);
    run_seq(0, 5, 0, 0, 1'b0);
    run_seq(0, 0, 0, 0, 1'b0);
    run_seq(5, 0, 0, 1, 1'b0);
    run_seq(12, 25, 2, 1, 1'b1);

    // Reset while the processor is running.
    clear_obs();
    @(posedge clock); #1;
    prog_len = 12; run_cycles = 25; start = 1'b1; src_valid = 1'b1; dump_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (work_cnt < 10 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("reached_run", 128'(work_cnt >= 10), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clock); #1;
    check_reset_outputs("held_reset");
    reset_n = 1'b1;
    run_seq(12, 25, 0, 0, 1'b0);

    for (int t = 0; t < 6; t++)
      run_seq($urandom_range(1, 40), $urandom_range(0, 30), $urandom_range(0, 2),
              $urandom_range(0, 1), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Run controller for the single-cycle `processor` core. On a `start` pulse it copies a program from a source memory into the processor's instruction memory over the `addr`/`wEn`/`wDat` write port while `working` is low. It then holds `working` high for a programmed number of cycles, drops it, and scans the register file through `rID`/`rdata`, streaming each register out on a valid/ready port. It replaces the hand-sequenced load/run/readout currently done by benches and host scripts.

## Interface
- `ADDR_W`, 9: instruction-memory address width.
- `DATA_W`, 32: instruction and register width.
- `RID_W`, 4: register-index width.
- `NREGS`, 16: number of registers dumped, indices 0..NREGS-1.
- `CYC_W`, 16: width of the run-cycle budget.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `prog_len` in ADDR_W: number of words to load; 0 skips LOAD.
- `run_cycles` in CYC_W: cycles `working` stays high; 0 skips RUN.
- `src_req` out 1: read request to the program source.
- `src_addr` out ADDR_W: source word index.
- `src_valid` in 1: `src_data` valid for current `src_addr`.
- `src_data` in DATA_W: program word.
- `addr` out ADDR_W: processor imem write address.
- `wEn` out 1: processor imem write enable.
- `wDat` out DATA_W: processor imem write data.
- `working` out 1: processor run enable.
- `rID` out RID_W: processor register read index.
- `rdata` in DATA_W: processor register read data.
- `dump_valid` out 1, `dump_ready` in 1: register dump handshake.
- `dump_id` out RID_W, `dump_data` out DATA_W: dumped register index and value.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a sequence.

## Operation
- States: IDLE → LOAD → RUN → DUMP → IDLE. `prog_len`/`run_cycles` are latched on `start`.
- **IDLE:** on `start`, go to LOAD. If the latched `prog_len`=0, go to RUN instead. If both are 0, go to DUMP.
  - `start` outside IDLE is ignored.
- **LOAD:**
  - `src_req`=1 with `src_addr`=k, held stable until `src_valid`. `src_valid` is ignored while `src_req`=0.
  - On an accept edge: register `addr`=k, `wDat`=`src_data`, `wEn`=1 for exactly one cycle, then k+1.
  - After the final accept, `src_req` drops. LOAD exits after the last `wEn` cycle.
- **RUN:** `working`=1 for exactly the latched `run_cycles` cycles; down-counter `run_cnt`.
- **DUMP:**
  - `working`=0, `rID`=i (starting at 0). One settle cycle follows, then `dump_valid`=1 with `dump_id`=i and `dump_data`=`rdata` captured.
  - Both are held until `dump_ready`. On the handshake, `dump_valid` drops, i increments, and settle repeats.
  - After i=NREGS-1 is accepted: `done`=1 for one cycle, then IDLE.
- **Counters:** `run_cnt` is unsigned and never wraps. The load index and `rID` saturate at their terminal values.
- **Exclusivity:** `wEn` and `working` are never high together.

## Timing
- **Reset values:** `src_req`=0, `src_addr`=0, `addr`=0, `wEn`=0, `wDat`=0, `working`=0, `rID`=0, `dump_valid`=0, `dump_id`=0, `dump_data`=0, `busy`=0, `done`=0; state=IDLE.
- **Reset mid-operation:** outputs take reset values immediately (async). A load or dump in progress is abandoned.
- **Load timing:** `start` sampled at edge E0; `src_req` rises after E0. With `src_valid` tied high:
  - word k is accepted at E0+1+k;
  - its `wEn` is high in cycle (E0+2+k, E0+3+k).
  - Throughput is 1 word/cycle.
- **Run timing:** `working` rises at the edge ending the last `wEn` cycle and stays high R=`run_cycles` cycles.
- **Dump timing:**
  - first `dump_valid` one cycle after `working` falls;
  - minimum 2 cycles per register with `dump_ready` tied high;
  - `done`/`busy` fall one edge after the last handshake.
- **Handshake rule:** `dump_ready` high with `dump_valid` low has no effect.

## Structure
- Package `proc_ctrl_pkg`: state enum (IDLE, LOAD, RUN, DUMP), default widths, NREGS.
- Sub-module `proc_run_timer`: loadable down-counter with `expired` flag, used for RUN.
- Everything else stays in one module.

## Test plan
- **Load, 12 words:** source ROM holds 10f00001, 10f1000a, 10f20014, 10f3001e, 10f40028, 10f50032, 41000065, 41100066, 41200067, 40300065, 40400066, 40500067; `prog_len`=12, `run_cycles`=25, `src_valid` tied high.
  - Expect 12 single-cycle `wEn` pulses at `addr` 0..11 with those words.
  - Expect `working` high exactly 25 cycles.
  - With the real processor, expect dump r3=1, r4=10, r5=20.
- **Stalled source:** `src_valid` asserted every 3rd cycle → `src_addr` stable while waiting; writes still 0..11 in order; no duplicate `wEn`.
- **Dump backpressure:** stub returns `rdata`=A0000000+`rID`; `dump_ready` toggled randomly → 16 dumps, ids 0..15 in order, data A0000000..A000000F, each held stable until accepted.
- **Skip cases:**
  - `prog_len`=0, `run_cycles`=5 → no `wEn`; `working` high 5 cycles.
  - both 0 → straight to DUMP.
- **Reset during RUN:** assert `reset_n`=0 at cycle 10 of 25 → `working`=0 asynchronously; all outputs at reset values; the next `start` runs a full sequence.
- **Start while busy:** `start` pulsed during LOAD and DUMP → ignored; exactly one `done` pulse.
